// File: rtl/alu_pkg.sv
// Shared opcode encoding and default datapath width for the ALU issue/retire slice.
package alu_pkg;

  localparam int ALU_WIDTH = 64;

  typedef logic [1:0] alu_op_t;

  localparam alu_op_t ALU_OP_AND = 2'd0;
  localparam alu_op_t ALU_OP_OR  = 2'd1;
  localparam alu_op_t ALU_OP_ADD = 2'd2;
  localparam alu_op_t ALU_OP_SUB = 2'd3;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Bundle of request, ALU-side and retire signals for alu_issue_stage.
// Optional flag outputs exist only when ALU_ISSUE_FLAGS_EN is defined.
import alu_pkg::*;

interface alu_issue_stage_if #(
  parameter int N     = ALU_WIDTH,
  parameter int TAG_W = 4
);
  // Both handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; the sender holds its payload stable while valid is high and ready low.
  logic             op_valid_i;
  logic             op_ready_o;
  alu_op_t          op_ctrl_i;
  logic [N-1:0]     op_a_i;
  logic [N-1:0]     op_b_i;
  alu_op_t          alu_control_o;
  logic [N-1:0]     alu_a_o;
  logic [N-1:0]     alu_b_o;
  logic [N-1:0]     alu_result_i;
  logic             alu_carry_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [N-1:0]     res_data_o;
  logic             res_carry_o;
  logic [TAG_W-1:0] res_tag_o;
`ifdef ALU_ISSUE_FLAGS_EN
  logic             res_zero_o;
  logic             res_neg_o;
  logic             res_ovf_o;
`endif

  modport slave (
    input  op_valid_i, op_ctrl_i, op_a_i, op_b_i, alu_result_i, alu_carry_i, res_ready_i,
    output op_ready_o, alu_control_o, alu_a_o, alu_b_o,
           res_valid_o, res_data_o, res_carry_o, res_tag_o
`ifdef ALU_ISSUE_FLAGS_EN
    , output res_zero_o, res_neg_o, res_ovf_o
`endif
  );

  modport master (
    output op_valid_i, op_ctrl_i, op_a_i, op_b_i, alu_result_i, alu_carry_i, res_ready_i,
    input  op_ready_o, alu_control_o, alu_a_o, alu_b_o,
           res_valid_o, res_data_o, res_carry_o, res_tag_o
`ifdef ALU_ISSUE_FLAGS_EN
    , input res_zero_o, res_neg_o, res_ovf_o
`endif
  );

endinterface

// File: rtl/pipe_valid_reg.sv
// Valid-tracked data register: load wins over clear; data holds when not loading.
module pipe_valid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage issue/retire wrapper around an external combinational ALU.
// Define ALU_ISSUE_FLAGS_EN to add registered zero/negative/overflow outputs.
import alu_pkg::*;

module alu_issue_stage #(
  parameter int N     = ALU_WIDTH,
  parameter int TAG_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  alu_issue_stage_if.slave   bus
);

  localparam int S1_W = 2 + 2 * N + TAG_W;
`ifdef ALU_ISSUE_FLAGS_EN
  localparam int S2_W = N + 1 + TAG_W + 3;
`else
  localparam int S2_W = N + 1 + TAG_W;
`endif

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_drain;
  logic             accept;
  logic [TAG_W-1:0] tag_cnt;
  logic [TAG_W-1:0] s1_tag;
  logic [S1_W-1:0]  s1_d;
  logic [S1_W-1:0]  s1_q;
  logic [S2_W-1:0]  s2_d;
  logic [S2_W-1:0]  s2_q;
  logic             carry_m;

  // Stage 1 may advance whenever stage 2 is empty or is retiring this cycle.
  assign s1_adv         = s1_valid & (~s2_valid | bus.res_ready_i);
  assign bus.op_ready_o = ~s1_valid | s1_adv;
  assign accept         = bus.op_valid_i & bus.op_ready_o;
  assign s2_drain       = s2_valid & bus.res_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_cnt <= '0;
    end else if (accept) begin
      tag_cnt <= tag_cnt + {{(TAG_W-1){1'b0}}, 1'b1};
    end
  end

  assign s1_d = {bus.op_ctrl_i, bus.op_a_i, bus.op_b_i, tag_cnt};

  pipe_valid_reg #(.W(S1_W)) u_s1 (
    .clk   (clk_i),
    .rst   (rst_i),
    .load  (accept),
    .clear (s1_adv),
    .d     (s1_d),
    .valid (s1_valid),
    .q     (s1_q)
  );

  assign {bus.alu_control_o, bus.alu_a_o, bus.alu_b_o, s1_tag} = s1_q;

  // Logic ops have no meaningful carry, so whatever the ALU drives is dropped.
  assign carry_m = bus.alu_control_o[1] & bus.alu_carry_i;

`ifdef ALU_ISSUE_FLAGS_EN
  logic zero_d;
  logic neg_d;
  logic ovf_d;

  always_comb begin
    zero_d = (bus.alu_result_i == '0);
    neg_d  = bus.alu_result_i[N-1];
    ovf_d  = 1'b0;
    case (bus.alu_control_o)
      ALU_OP_ADD: ovf_d = (bus.alu_a_o[N-1] == bus.alu_b_o[N-1]) &&
                          (bus.alu_result_i[N-1] != bus.alu_a_o[N-1]);
      ALU_OP_SUB: ovf_d = (bus.alu_a_o[N-1] != bus.alu_b_o[N-1]) &&
                          (bus.alu_result_i[N-1] != bus.alu_a_o[N-1]);
      default:    ovf_d = 1'b0;
    endcase
  end

  assign s2_d = {bus.alu_result_i, carry_m, s1_tag, zero_d, neg_d, ovf_d};
  assign {bus.res_data_o, bus.res_carry_o, bus.res_tag_o,
          bus.res_zero_o, bus.res_neg_o, bus.res_ovf_o} = s2_q;
`else
  assign s2_d = {bus.alu_result_i, carry_m, s1_tag};
  assign {bus.res_data_o, bus.res_carry_o, bus.res_tag_o} = s2_q;
`endif

  pipe_valid_reg #(.W(S2_W)) u_s2 (
    .clk   (clk_i),
    .rst   (rst_i),
    .load  (s1_adv),
    .clear (s2_drain),
    .d     (s2_d),
    .valid (s2_valid),
    .q     (s2_q)
  );

  assign bus.res_valid_o = s2_valid;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Pipelined issue/retire wrapper around the combinational ALU datapath (AND/OR/add/sub, 2-bit alu_control).
- Stage 1: accepts operation requests over a valid/ready handshake, registers opcode and operands, and drives the ALU inputs.
- Stage 2: captures the ALU result and carry into a retire register with its own valid/ready handshake toward the register-file writeback.
- Throughput is one op per cycle under no backpressure.

Parameters:
N, 64, operand/result width in bits.
TAG_W, 4, width of the per-op sequence tag.

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous active-high reset
op_valid_i  input  1  request valid
op_ready_o  output  1  request accepted when op_valid_i & op_ready_o
op_ctrl_i  input  2  opcode: 0 AND, 1 OR, 2 ADD, 3 SUB
op_a_i  input  N  operand A
op_b_i  input  N  operand B
alu_control_o  output  2  registered opcode to ALU
alu_a_o  output  N  registered operand A to ALU
alu_b_o  output  N  registered operand B to ALU
alu_result_i  input  N  ALU result (combinational from alu_*_o)
alu_carry_i  input  1  ALU carry/borrow out
res_valid_o  output  1  retire data valid
res_ready_i  input  1  downstream ready
res_data_o  output  N  registered result
res_carry_o  output  1  registered carry, forced 0 for AND/OR
res_tag_o  output  TAG_W  sequence tag of the retired op

Behaviour:
Reset:
- On rst_i high at a clock edge: s1_valid=0, s2_valid=0, tag counter=0.
- All data registers, alu_*_o, res_data_o, res_carry_o and res_tag_o are cleared to 0.
- res_valid_o=0 and op_ready_o=1 in the first cycle after reset.
- Reset mid-operation silently discards in-flight ops; no res_valid_o pulse results.

Handshake rules:
- s1_adv = s1_valid & (!s2_valid | res_ready_i).
- op_ready_o = !s1_valid | s1_adv. This is a combinational path from res_ready_i, which is allowed.
- Accept (op_valid_i & op_ready_o): stage 1 loads op_ctrl_i, op_a_i, op_b_i and tag counter; s1_valid<=1; tag counter increments mod 2^TAG_W (wraps 15->0 at TAG_W=4).
- s1_adv without a new accept: s1_valid<=0. Stage 1 data holds its last value.
- s1_adv: stage 2 loads alu_result_i, alu_carry_i (masked to 0 when opcode is 0 or 1) and the stage-1 tag; s2_valid<=1.
- s2 drains when res_valid_o & res_ready_i and no s1_adv in the same cycle: s2_valid<=0.

Latency and ordering:
- Latency is 2 cycles: an op accepted at edge k appears on res_valid_o after edge k+1.
- Ops retire strictly in order.

Backpressure and boundary conditions:
- While res_ready_i=0 and both stages are full, op_ready_o=0 and all registered outputs hold stable.
- When res_valid_o=1, res_data_o, res_carry_o and res_tag_o must not change until the handshake completes.
- Simultaneous accept + s1_adv + s2 drain: all three occur in the same cycle, with no bubble.
- op_valid_i with op_ready_o=0: the request is ignored, and the requester must hold its values stable.

Arithmetic:
- The block performs no arithmetic itself; width is N throughout.
- The ALU's SUB carry is passed through unmodified.

Optional Feature:
ALU_ISSUE_FLAGS_EN. When defined, adds registered outputs, all captured into stage 2 on s1_adv and cleared on reset:
- res_zero_o (res_data == 0)
- res_neg_o (MSB of result)
- res_ovf_o (signed overflow):
  - ADD: a[N-1]==b[N-1] && r[N-1]!=a[N-1].
  - SUB: a[N-1]!=b[N-1] && r[N-1]!=a[N-1].
  - Otherwise 0.
When not defined, these ports and registers do not exist; the remaining behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - opcode constants ALU_OP_AND=0, ALU_OP_OR=1, ALU_OP_ADD=2, ALU_OP_SUB=3
  - a typedef for the 2-bit opcode
  - default width constant 64
- One sub-module is natural: pipe_valid_reg, a generic valid-tracked data register with load/clear enables. It is instantiated for stage 1 and for stage 2; handshake logic stays in the top.

Test Plan:
1. Reset then single ADD A=0xFFFF_FFFF_FFFF_FFFF, B=1, res_ready_i=1 -> res_valid_o 2 cycles after accept, res_data_o=0, res_carry_o=1, res_tag_o=0.
2. Back-to-back AND, OR, ADD, SUB with res_ready_i=1 -> op_ready_o stays 1; results retire on 4 consecutive cycles with tags 0,1,2,3; AND/OR carry=0.
3. Fill both stages, hold res_ready_i=0 for 5 cycles -> op_ready_o=0 and res_* stable; release -> next accept occurs in the same cycle as the drain.
4. Issue 17 ops -> tags 0..15 then 0, in order, none lost or duplicated.
5. Assert rst_i with both stages full -> next cycle res_valid_o=0, op_ready_o=1, and no stale result ever retires.
6. ALU_ISSUE_FLAGS_EN: SUB A=0x8000_0000_0000_0000, B=1 -> res_ovf_o=1, res_neg_o=0, res_zero_o=0; AND A=0xF0, B=0x0F -> res_zero_o=1.
